simd_op_sequencer: RTL and testbench
====================================

SIMD_OP_SEQUENCER -- requirements
Module: simd_op_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 3, ALU opcode width.
REQ-002 SHALL have parameter LANES, default 4, parallel 32-bit ALU lanes.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, vector-memory word address width (1 word = LANES*32 bits).
REQ-004 SHALL have parameter LEN_WIDTH, default 8, beat-count width.
REQ-005 SHALL have ports: clk in 1, rising-edge clock; rstn in 1, reset. One clock; reset is synchronous and active-low.
REQ-006 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_opcode in OPCODE_WIDTH; cmd_len in LEN_WIDTH (beats); cmd_src_a, cmd_src_b, cmd_dst in ADDR_WIDTH each.
REQ-007 SHALL have read ports: mem_rd_en out 1; mem_rd_addr_a, mem_rd_addr_b out ADDR_WIDTH; mem_rd_data_a, mem_rd_data_b in LANES*32 (valid the cycle after mem_rd_en).
REQ-008 SHALL have ALU ports: alu_opcode out OPCODE_WIDTH (broadcast to all lanes); alu_a, alu_b out LANES*32; alu_out in LANES*32 (registered ALU, valid the cycle after operands).
REQ-009 SHALL have write ports: mem_wr_en out 1; mem_wr_addr out ADDR_WIDTH; mem_wr_data out LANES*32.
REQ-010 SHALL have status ports: busy out 1; done out 1 (single-cycle pulse).

Function
REQ-011 Opcode encoding SHALL be NOOP=0, ADD=1, SUB=2, MUL=3, DOTP=4, STORE_TEMP_S1=5, STORE_TEMP_S2=6, STORE_RESULT=7.
REQ-012 States SHALL be IDLE, ISSUE, DRAIN, DOT_WR, DONE; cmd_ready=1 only in IDLE; busy=1 in every state except IDLE.
REQ-013 Accept when cmd_valid && cmd_ready at edge 0; all cmd_* fields latched at that edge.
REQ-014 Opcodes ADD/SUB/MUL/DOTP with cmd_len>0: IDLE->ISSUE; other opcodes or cmd_len=0: IDLE->DONE, no memory or ALU activity.
REQ-015 ISSUE: cycles 1..N (N=cmd_len) assert mem_rd_en with addresses src_a+i, src_b+i, i=0..N-1; then ->DRAIN.
REQ-016 Cycle after each read (1..N shifted +1): alu_a=mem_rd_data_a, alu_b=mem_rd_data_b, alu_opcode=latched opcode; otherwise alu_opcode=NOOP and alu_a/alu_b=0.
REQ-017 ADD/SUB/MUL: two cycles after read i, mem_wr_en=1, mem_wr_addr=dst+i, mem_wr_data=alu_out; writes land in cycles 3..N+2.
REQ-018 DRAIN SHALL last 2 cycles (N+1, N+2); then ->DOT_WR for DOTP, else ->DONE.
REQ-019 DOTP: no per-beat writes; 32-bit accumulator cleared on accept, adds sum of all LANES 32-bit lanes of alu_out each valid cycle, modulo 2^32.
REQ-020 DOT_WR (cycle N+3): mem_wr_en=1, mem_wr_addr=dst, mem_wr_data lane0=accumulator, other lanes 0; ->DONE.
REQ-021 DONE: done=1 for exactly one cycle, ->IDLE; ADD/SUB/MUL done at cycle N+3, DOTP at N+4, no-op commands at cycle 1.
REQ-022 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-023 cmd_valid outside IDLE SHALL be ignored, with cmd_* not sampled; back-to-back commands minimum gap = DONE + 1 IDLE cycle.

Reset
REQ-024 While rstn=0 at a clock edge: state=IDLE, cmd_ready=0 during reset then 1 the cycle after release; busy=0, done=0, mem_rd_en=0, mem_wr_en=0, alu_opcode=NOOP, all address/data outputs 0, accumulator 0.
REQ-025 Reset mid-operation SHALL abort immediately; in-flight reads/ALU results discarded, no write or done issued after reset.

Verification
REQ-026 ADD, len=3, src_a=0x10, src_b=0x20, dst=0x30, lane data a=k, b=2k -> writes 0x30..0x32 at cycles 3..5 with lane value 3k; done at cycle 6.
REQ-027 SUB, len=1, a=5, b=7 per lane -> single write 0xFFFFFFFE per lane at cycle 3; done cycle 4.
REQ-028 DOTP, len=2, LANES=4, all-lane products 3 -> one write at cycle 5, lane0=24, other lanes 0; done cycle 6.
REQ-029 cmd_len=0 ADD and STORE_RESULT commands -> no rd_en/wr_en, done at cycle 1, cmd_ready high cycle 2.
REQ-030 src_a=2^ADDR_WIDTH-1, len=2 -> read addresses 0x3FF then 0x000.
REQ-031 rstn low at cycle 2 of MUL len=4 -> no further mem_wr_en/done; new command accepted normally after release.

Source files
------------

// File: rtl/simd_op_sequencer.sv
// Purpose: sequences one vector command (read A/B, drive lane ALUs, write back or reduce to a dot product).
// Latency: ADD/SUB/MUL done at cycle len+3, DOTP at len+4, no-op commands at cycle 1 after accept.
// Backpressure: cmd_ready only in IDLE; memory and ALU are fixed-latency, so there is no stall path.
module simd_op_sequencer #(
    parameter int OPCODE_WIDTH = 3,
    parameter int LANES        = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [ADDR_WIDTH-1:0]   cmd_src_a,
    input  logic [ADDR_WIDTH-1:0]   cmd_src_b,
    input  logic [ADDR_WIDTH-1:0]   cmd_dst,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr_a,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr_b,
    input  logic [LANES*32-1:0]     mem_rd_data_a,
    input  logic [LANES*32-1:0]     mem_rd_data_b,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    output logic [LANES*32-1:0]     alu_a,
    output logic [LANES*32-1:0]     alu_b,
    input  logic [LANES*32-1:0]     alu_out,
    output logic                    mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [LANES*32-1:0]     mem_wr_data,
    output logic                    busy,
    output logic                    done
);

    // Only the opcodes that steer the datapath are named here; STORE_TEMP_S1/S2,
    // STORE_RESULT and NOOP all complete immediately with no memory traffic.
    localparam logic [OPCODE_WIDTH-1:0] OP_NOOP = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_DOTP = OPCODE_WIDTH'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DOT_WR,
        S_DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [OPCODE_WIDTH-1:0] op_q;
    logic [LEN_WIDTH-1:0]    len_left_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_a_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_b_q;
    // Holds dst for DOTP (never advances) and the running write address otherwise.
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic                    drain_q;
    logic                    rd_vld_d1_q;
    logic                    rd_vld_d2_q;
    logic [31:0]             acc_q;

    logic                    accept;
    logic                    is_alu_cmd;
    logic                    issue;
    logic                    dot_wr;
    logic                    alu_stage;
    logic                    wr_beat;
    logic [31:0]             lane_sum;
    logic [LANES*32-1:0]     dot_word;

    assign is_alu_cmd = (cmd_opcode == OP_ADD) || (cmd_opcode == OP_SUB) ||
                        (cmd_opcode == OP_MUL) || (cmd_opcode == OP_DOTP);
    assign accept     = cmd_valid && cmd_ready;

    // State register; reset returns to IDLE and abandons any command in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes; strobes are masked while reset is held so an abort is immediate.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        issue     = 1'b0;
        dot_wr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (is_alu_cmd && (cmd_len != '0)) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                issue = 1'b1;
                if (len_left_q == LEN_WIDTH'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    state_d = (op_q == OP_DOTP) ? S_DOT_WR : S_DONE;
                end
            end
            S_DOT_WR: begin
                dot_wr  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (!rstn) begin
            cmd_ready = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
            issue     = 1'b0;
            dot_wr    = 1'b0;
        end
    end

    // Command latch, beat/address counters, read-valid pipeline and dot-product accumulator.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_q        <= OP_NOOP;
            len_left_q  <= '0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            wr_addr_q   <= '0;
            drain_q     <= 1'b0;
            rd_vld_d1_q <= 1'b0;
            rd_vld_d2_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            if (accept) begin
                op_q        <= cmd_opcode;
                len_left_q  <= cmd_len;
                rd_addr_a_q <= cmd_src_a;
                rd_addr_b_q <= cmd_src_b;
                wr_addr_q   <= cmd_dst;
                acc_q       <= '0;
            end else begin
                if (issue) begin
                    len_left_q  <= len_left_q - LEN_WIDTH'(1);
                    rd_addr_a_q <= rd_addr_a_q + ADDR_WIDTH'(1);
                    rd_addr_b_q <= rd_addr_b_q + ADDR_WIDTH'(1);
                end
                if (wr_beat) begin
                    wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
                end
                if (rd_vld_d2_q && (op_q == OP_DOTP)) begin
                    acc_q <= acc_q + lane_sum;
                end
            end
            drain_q     <= (state_q == S_DRAIN) && !drain_q;
            rd_vld_d1_q <= issue;
            rd_vld_d2_q <= rd_vld_d1_q;
        end
    end

    // Horizontal sum of all lanes of the ALU result, wrapping at 32 bits.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + alu_out[l*32 +: 32];
        end
    end

    // Dot-product result word: accumulator in lane 0, remaining lanes zero.
    always_comb begin
        dot_word       = '0;
        dot_word[31:0] = acc_q;
    end

    assign alu_stage = rstn && rd_vld_d1_q;
    assign wr_beat   = rstn && rd_vld_d2_q && (op_q != OP_DOTP);

    assign mem_rd_en     = issue;
    assign mem_rd_addr_a = issue ? rd_addr_a_q : '0;
    assign mem_rd_addr_b = issue ? rd_addr_b_q : '0;

    assign alu_opcode = alu_stage ? op_q : OP_NOOP;
    assign alu_a      = alu_stage ? mem_rd_data_a : '0;
    assign alu_b      = alu_stage ? mem_rd_data_b : '0;

    assign mem_wr_en   = wr_beat || dot_wr;
    assign mem_wr_addr = (wr_beat || dot_wr) ? wr_addr_q : '0;
    assign mem_wr_data = dot_wr ? dot_word : (wr_beat ? alu_out : '0);

endmodule

// File: tb/tb_simd_op_sequencer.sv
// Purpose: directed, table-driven check of simd_op_sequencer with a behavioural memory and lane ALU.
// Latency: each vector runs to its done pulse plus one IDLE cycle; all waits are cycle-bounded.
// Backpressure: commands are offered only when the sequencer should be idle; some vectors hold cmd_valid while busy.
module tb_simd_op_sequencer;

    localparam int DW = 128;

    logic           clk = 1'b0;
    logic           rstn;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_opcode;
    logic [7:0]     cmd_len;
    logic [9:0]     cmd_src_a;
    logic [9:0]     cmd_src_b;
    logic [9:0]     cmd_dst;
    logic           mem_rd_en;
    logic [9:0]     mem_rd_addr_a;
    logic [9:0]     mem_rd_addr_b;
    logic [DW-1:0]  mem_rd_data_a;
    logic [DW-1:0]  mem_rd_data_b;
    logic [2:0]     alu_opcode;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [DW-1:0]  alu_out;
    logic           mem_wr_en;
    logic [9:0]     mem_wr_addr;
    logic [DW-1:0]  mem_wr_data;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem_a [0:1023];
    logic [DW-1:0] mem_b [0:1023];

    simd_op_sequencer dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_len(cmd_len), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .mem_rd_en(mem_rd_en), .mem_rd_addr_a(mem_rd_addr_a), .mem_rd_addr_b(mem_rd_addr_b),
        .mem_rd_data_a(mem_rd_data_a), .mem_rd_data_b(mem_rd_data_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a * b;
            3'd4:    return a * b;
            default: return 32'd0;
        endcase
    endfunction

    // One-cycle read memory model.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data_a <= mem_a[mem_rd_addr_a];
            mem_rd_data_b <= mem_b[mem_rd_addr_b];
        end
    end

    // Registered lane ALU model.
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            alu_out[l*32 +: 32] <= ref_alu(alu_opcode, alu_a[l*32 +: 32], alu_b[l*32 +: 32]);
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  len;
        logic [9:0]  sa;
        logic [9:0]  sb;
        logic [9:0]  dst;
        logic [31:0] a0;
        logic [31:0] astep;
        logic [31:0] lane_inc;
        logic [31:0] b0;
        logic [31:0] bstep;
        int          exp_reads;
        int          exp_writes;
        int          exp_done;
        logic [31:0] exp_dot;
        bit          hold;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_a(input vec_t v, input int i);
        logic [DW-1:0] w;
        for (int l = 0; l < 4; l++) w[l*32 +: 32] = v.a0 + 32'(i) * v.astep + 32'(l) * v.lane_inc;
        return w;
    endfunction

    function automatic logic [DW-1:0] word_b(input vec_t v, input int i);
        logic [DW-1:0] w;
        for (int l = 0; l < 4; l++) w[l*32 +: 32] = v.b0 + 32'(i) * v.bstep;
        return w;
    endfunction

    function automatic logic [DW-1:0] exp_word(input vec_t v, input int i);
        logic [DW-1:0] wa;
        logic [DW-1:0] wb;
        logic [DW-1:0] w;
        wa = word_a(v, i);
        wb = word_b(v, i);
        for (int l = 0; l < 4; l++) w[l*32 +: 32] = ref_alu(v.op, wa[l*32 +: 32], wb[l*32 +: 32]);
        return w;
    endfunction

    // Entered just after a rising edge with the DUT idle; leaves just after the edge following the IDLE check.
    task automatic run_vec(input vec_t v);
        int rd;
        int wr;
        int done_cyc;
        logic [9:0] ea;
        logic [9:0] eb;
        for (int i = 0; i < int'(v.len); i++) begin
            ea = v.sa + 10'(i);
            eb = v.sb + 10'(i);
            mem_a[ea] = word_a(v, i);
            mem_b[eb] = word_b(v, i);
        end
        cmd_valid  = 1'b1;
        cmd_opcode = v.op;
        cmd_len    = v.len;
        cmd_src_a  = v.sa;
        cmd_src_b  = v.sb;
        cmd_dst    = v.dst;
        @(negedge clk);
        check("accept_ready", cmd_ready, 1);
        @(posedge clk); #1;
        if (v.hold) begin
            cmd_opcode = 3'd1;
            cmd_len    = 8'd7;
            cmd_src_a  = 10'h2AA;
            cmd_src_b  = 10'h155;
            cmd_dst    = 10'h0F0;
        end else begin
            cmd_valid = 1'b0;
        end
        rd = 0;
        wr = 0;
        done_cyc = -1;
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("busy_c1", busy, 1);
                check("ready_c1", cmd_ready, 0);
            end
            if (mem_rd_en) begin
                ea = v.sa + 10'(rd);
                eb = v.sb + 10'(rd);
                check("rd_addr_a", mem_rd_addr_a, ea);
                check("rd_addr_b", mem_rd_addr_b, eb);
                check("rd_cycle", c, rd + 1);
                rd++;
            end
            if (alu_opcode != 3'd0) begin
                check("alu_op", alu_opcode, v.op);
                check("alu_a", alu_a, word_a(v, c - 2));
                check("alu_b", alu_b, word_b(v, c - 2));
            end
            if (mem_wr_en) begin
                if (v.op == 3'd4) begin
                    check("dot_addr", mem_wr_addr, v.dst);
                    check("dot_data", mem_wr_data, {96'b0, v.exp_dot});
                    check("dot_cycle", c, int'(v.len) + 3);
                end else begin
                    ea = v.dst + 10'(wr);
                    check("wr_addr", mem_wr_addr, ea);
                    check("wr_data", mem_wr_data, exp_word(v, wr));
                    check("wr_cycle", c, wr + 3);
                end
                wr++;
            end
            if (done) done_cyc = c;
            @(posedge clk); #1;
            if (done_cyc >= 0) cmd_valid = 1'b0;
        end
        check("done_cycle", done_cyc, v.exp_done);
        check("read_count", rd, v.exp_reads);
        check("write_count", wr, v.exp_writes);
        @(negedge clk);
        check("ready_after", cmd_ready, 1);
        check("busy_after", busy, 0);
        check("done_pulse", done, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int nwr;
        int nrd;
        int ndone;
        //           op    len    sa      sb      dst     a0  as  li  b0  bs  rd wr dn dot  hold
        vecs[0] = '{3'd1, 8'd3, 10'h010, 10'h020, 10'h030, 1,  1,  0,  2,  2,  3, 3, 6, 0,   0};
        vecs[1] = '{3'd2, 8'd1, 10'h005, 10'h006, 10'h007, 5,  0,  0,  7,  0,  1, 1, 4, 0,   1};
        vecs[2] = '{3'd4, 8'd2, 10'h040, 10'h050, 10'h060, 1,  0,  0,  3,  0,  2, 1, 6, 24,  0};
        vecs[3] = '{3'd1, 8'd0, 10'h011, 10'h022, 10'h033, 1,  0,  0,  1,  0,  0, 0, 1, 0,   1};
        vecs[4] = '{3'd7, 8'd5, 10'h011, 10'h022, 10'h033, 1,  0,  0,  1,  0,  0, 0, 1, 0,   0};
        vecs[5] = '{3'd3, 8'd2, 10'h3FF, 10'h100, 10'h3FF, 3,  1,  1,  4,  0,  2, 2, 5, 0,   0};
        vecs[6] = '{3'd4, 8'd3, 10'h200, 10'h210, 10'h220, 2,  1,  1,  5,  0,  3, 1, 7, 270, 0};
        vecs[7] = '{3'd0, 8'd3, 10'h011, 10'h022, 10'h033, 1,  0,  0,  1,  0,  0, 0, 1, 0,   0};

        rstn       = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_len    = '0;
        cmd_src_a  = '0;
        cmd_src_b  = '0;
        cmd_dst    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_alu_op", alu_opcode, 0);
        check("rst_rd_addr", mem_rd_addr_a, 0);
        check("rst_wr_addr", mem_wr_addr, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_wr_data", mem_wr_data, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("ready_release", cmd_ready, 1);
        @(posedge clk); #1;

        for (int k = 0; k < 8; k++) run_vec(vecs[k]);

        // Reset during cycle 2 of a MUL len=4 command.
        cmd_valid  = 1'b1;
        cmd_opcode = 3'd3;
        cmd_len    = 8'd4;
        cmd_src_a  = 10'h080;
        cmd_src_b  = 10'h090;
        cmd_dst    = 10'h0A0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        check("abort_rd_en", mem_rd_en, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", cmd_ready, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        nwr = 0;
        nrd = 0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_wr_en) nwr++;
            if (mem_rd_en) nrd++;
            if (done) ndone++;
            @(posedge clk); #1;
        end
        check("abort_writes", nwr, 0);
        check("abort_reads", nrd, 0);
        check("abort_done", ndone, 0);
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
